// File: rtl/rv32imf_obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32imf_obi_mem_arbiter
// Description : Shares one OBI memory port between the fetch and load/store
//               masters, tracking response ownership in an in-order FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32imf_obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit DATA_PRIO       = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 instr_req_i,
    output logic                                 instr_gnt_o,
    input  logic [31:0]                          instr_addr_i,
    output logic                                 instr_rvalid_o,
    output logic [31:0]                          instr_rdata_o,
    output logic                                 instr_err_o,
    input  logic                                 data_req_i,
    output logic                                 data_gnt_o,
    input  logic [31:0]                          data_addr_i,
    input  logic                                 data_we_i,
    input  logic [3:0]                           data_be_i,
    input  logic [31:0]                          data_wdata_i,
    input  logic [5:0]                           data_atop_i,
    output logic                                 data_rvalid_o,
    output logic [31:0]                          data_rdata_o,
    output logic                                 data_err_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic [31:0]                          mem_addr_o,
    output logic                                 mem_we_o,
    output logic [3:0]                           mem_be_o,
    output logic [31:0]                          mem_wdata_o,
    output logic [5:0]                           mem_atop_o,
    input  logic                                 mem_rvalid_i,
    input  logic [31:0]                          mem_rdata_i,
    input  logic                                 mem_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 busy_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] c_cnt_max  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] c_ptr_last = PW'(MAX_OUTSTANDING - 1);
    localparam logic          c_side_i   = 1'b0;
    localparam logic          c_side_d   = 1'b1;

    logic                       lock_q, lock_d;
    logic                       owner_q, owner_d;
    logic                       rr_last_q, rr_last_d;
    logic [MAX_OUTSTANDING-1:0] trk_q, trk_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic w_sel;
    logic w_sel_req;
    logic w_grant;
    logic w_pop;
    logic w_head;
    logic w_unused_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_ptr_last) ? '0 : p + PW'(1);
    endfunction

    assign w_unused_addr = ^instr_addr_i[1:0];

    // A stalled address phase keeps its owner so the presented request never changes before gnt.
    always_comb begin
        w_sel = c_side_i;
        if (lock_q) begin
            w_sel = owner_q;
        end else if (instr_req_i && data_req_i) begin
            w_sel = (DATA_PRIO != 1'b0) ? c_side_d : ~rr_last_q;
        end else begin
            w_sel = data_req_i;
        end
    end

    assign w_sel_req = w_sel ? data_req_i : instr_req_i;
    assign mem_req_o = !rst && w_sel_req && (cnt_q != c_cnt_max);
    assign w_grant   = mem_req_o && mem_gnt_i;

    assign mem_addr_o  = w_sel ? data_addr_i  : {instr_addr_i[31:2], 2'b00};
    assign mem_we_o    = w_sel && data_we_i;
    assign mem_be_o    = w_sel ? data_be_i    : 4'b1111;
    assign mem_wdata_o = w_sel ? data_wdata_i : 32'd0;
    assign mem_atop_o  = w_sel ? data_atop_i  : 6'd0;

    assign instr_gnt_o = w_grant && (w_sel == c_side_i);
    assign data_gnt_o  = w_grant && (w_sel == c_side_d);

    // Responses with nothing outstanding belong to no one and are discarded.
    assign w_pop          = !rst && mem_rvalid_i && (cnt_q != '0);
    assign w_head         = trk_q[rd_ptr_q];
    assign instr_rvalid_o = w_pop && (w_head == c_side_i);
    assign data_rvalid_o  = w_pop && (w_head == c_side_d);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign outstanding_o = rst ? '0 : cnt_q;
    assign busy_o        = !rst && ((cnt_q != '0) || mem_req_o);

    always_comb begin
        lock_d    = lock_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        trk_d     = trk_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (w_grant) begin
            lock_d          = 1'b0;
            rr_last_d       = w_sel;
            trk_d[wr_ptr_q] = w_sel;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else if (mem_req_o) begin
            lock_d  = 1'b1;
            owner_d = w_sel;
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (w_grant && !w_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!w_grant && w_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            owner_q   <= c_side_i;
            rr_last_q <= c_side_i;
            trk_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            trk_q     <= trk_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32imf_obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32imf_obi_mem_arbiter
// Description : Two arbiter instances (fixed data priority, round-robin)
//               checked every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32imf_obi_mem_arbiter;

    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ireq [2], dreq [2], dwe [2], mgnt [2], mrv [2], merr [2];
    logic [31:0]   iaddr [2], daddr [2], dwd [2], mrd [2];
    logic [3:0]    dbe [2];
    logic [5:0]    datop [2];

    logic          igo [2], irv [2], ierr [2], dgo [2], drv_o [2], derr [2];
    logic [31:0]   ird [2], drd [2];
    logic          mreq [2], mwe [2], busy [2];
    logic [31:0]   maddr [2], mwd [2];
    logic [3:0]    mbe [2];
    logic [5:0]    matop [2];
    logic [CW-1:0] outst [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rv32imf_obi_mem_arbiter #(
            .MAX_OUTSTANDING (MO),
            .DATA_PRIO       ((g == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .instr_req_i    (ireq[g]),
            .instr_gnt_o    (igo[g]),
            .instr_addr_i   (iaddr[g]),
            .instr_rvalid_o (irv[g]),
            .instr_rdata_o  (ird[g]),
            .instr_err_o    (ierr[g]),
            .data_req_i     (dreq[g]),
            .data_gnt_o     (dgo[g]),
            .data_addr_i    (daddr[g]),
            .data_we_i      (dwe[g]),
            .data_be_i      (dbe[g]),
            .data_wdata_i   (dwd[g]),
            .data_atop_i    (datop[g]),
            .data_rvalid_o  (drv_o[g]),
            .data_rdata_o   (drd[g]),
            .data_err_o     (derr[g]),
            .mem_req_o      (mreq[g]),
            .mem_gnt_i      (mgnt[g]),
            .mem_addr_o     (maddr[g]),
            .mem_we_o       (mwe[g]),
            .mem_be_o       (mbe[g]),
            .mem_wdata_o    (mwd[g]),
            .mem_atop_o     (matop[g]),
            .mem_rvalid_i   (mrv[g]),
            .mem_rdata_i    (mrd[g]),
            .mem_err_i      (merr[g]),
            .outstanding_o  (outst[g]),
            .busy_o         (busy[g])
        );
    end

    // Reference model: owners of unanswered transactions, a pending (stalled) request, last winner.
    bit oq [2][$];
    bit pend [2];
    bit pend_side [2];
    bit last_win [2];
    bit e_side [2], e_mreq [2], e_gnt [2], e_pop [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", tag, k, $time, got, exp);
        end
    endtask

    task automatic eval(input int k);
        int cnt;
        bit side, want, mr, g, p;
        cnt = oq[k].size();
        if (pend[k])                 side = pend_side[k];
        else if (ireq[k] && dreq[k]) side = (k == 0) ? 1'b1 : !last_win[k];
        else                         side = dreq[k];
        want = side ? dreq[k] : ireq[k];
        mr   = !rst && want && (cnt < MO);
        g    = mr && mgnt[k];
        p    = !rst && mrv[k] && (cnt > 0);
        e_side[k] = side; e_mreq[k] = mr; e_gnt[k] = g; e_pop[k] = p;
        chk("mem_req", k, 32'(mreq[k]), 32'(mr));
        chk("instr_gnt", k, 32'(igo[k]), 32'(g && !side));
        chk("data_gnt", k, 32'(dgo[k]), 32'(g && side));
        if (mr) begin
            chk("mem_addr", k, maddr[k], side ? daddr[k] : (iaddr[k] & 32'hFFFF_FFFC));
            chk("mem_we", k, 32'(mwe[k]), side ? 32'(dwe[k]) : 32'd0);
            chk("mem_be", k, 32'(mbe[k]), side ? 32'(dbe[k]) : 32'hF);
            chk("mem_wdata", k, mwd[k], side ? dwd[k] : 32'd0);
            chk("mem_atop", k, 32'(matop[k]), side ? 32'(datop[k]) : 32'd0);
        end
        chk("instr_rvalid", k, 32'(irv[k]), 32'(p && (oq[k][0] == 1'b0)));
        chk("data_rvalid", k, 32'(drv_o[k]), 32'(p && (oq[k][0] == 1'b1)));
        if (p) begin
            chk("rdata", k, oq[k][0] ? drd[k] : ird[k], mrd[k]);
            chk("err", k, 32'(oq[k][0] ? derr[k] : ierr[k]), 32'(merr[k]));
        end
        chk("outstanding", k, 32'(outst[k]), rst ? 32'd0 : 32'(cnt));
        chk("busy", k, 32'(busy[k]), 32'(!rst && (cnt > 0 || mr)));
    endtask

    task automatic update(input int k);
        if (rst) begin
            oq[k].delete();
            pend[k]     = 1'b0;
            last_win[k] = 1'b0;
        end else begin
            if (e_pop[k]) void'(oq[k].pop_front());
            if (e_gnt[k]) begin
                oq[k].push_back(e_side[k]);
                last_win[k] = e_side[k];
                pend[k]     = 1'b0;
            end else if (e_mreq[k]) begin
                pend[k]      = 1'b1;
                pend_side[k] = e_side[k];
            end
        end
    endtask

    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) eval(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) update(k);
        @(negedge clk);
    endtask

    task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                       input bit mg, input bit mv);
        for (int k = 0; k < 2; k++) begin
            ireq[k] = ir; iaddr[k] = ia; dreq[k] = dr; daddr[k] = da;
            dwe[k] = 1'($urandom); dbe[k] = 4'($urandom); dwd[k] = $urandom; datop[k] = 6'($urandom);
            mgnt[k] = mg; mrv[k] = mv; mrd[k] = $urandom; merr[k] = 1'($urandom);
        end
    endtask

    // Requests stay stable until granted, then may change.
    task automatic rnd_next(input int k);
        if (!ireq[k] || (e_gnt[k] && !e_side[k])) begin
            ireq[k] = 1'($urandom); iaddr[k] = $urandom;
        end
        if (!dreq[k] || (e_gnt[k] && e_side[k])) begin
            dreq[k] = 1'($urandom); daddr[k] = $urandom; dwe[k] = 1'($urandom);
            dbe[k] = 4'($urandom); dwd[k] = $urandom; datop[k] = 6'($urandom);
        end
        mgnt[k] = ($urandom % 4) != 0;
        mrv[k]  = ($urandom % 3) == 0;
        mrd[k]  = $urandom;
        merr[k] = ($urandom % 8) == 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; pend_side[k] = 1'b0; last_win[k] = 1'b0;
            e_side[k] = 1'b0; e_mreq[k] = 1'b0; e_gnt[k] = 1'b0; e_pop[k] = 1'b0;
        end
        rst = 1'b1;
        drv(1, 32'h0000_0040, 1, 32'h0000_1000, 1, 0);
        repeat (3) tick();
        rst = 1'b0;

        // Priority: data first, then fetch; responses in grant order.
        drv(1, 32'h0000_0207, 1, 32'h0000_2000, 1, 0); tick();
        drv(1, 32'h0000_0207, 0, 32'h0000_2000, 1, 0); tick();
        drv(0, 32'h0, 0, 32'h0, 0, 1); tick(); tick();

        // Stalled fetch keeps the port while data arrives.
        drv(1, 32'h0000_0100, 0, 32'h0000_3000, 0, 0); tick();
        drv(1, 32'h0000_0100, 1, 32'h0000_3000, 0, 0); tick(); tick();
        drv(1, 32'h0000_0100, 1, 32'h0000_3000, 1, 0); tick();
        drv(0, 32'h0000_0100, 1, 32'h0000_3000, 1, 0); tick();
        drv(0, 32'h0, 0, 32'h0, 0, 1); tick(); tick();

        // Tracker full, then simultaneous push and pop.
        drv(0, 32'h0, 1, 32'h0000_4000, 1, 0); tick();
        drv(0, 32'h0, 1, 32'h0000_4004, 1, 0); tick();
        drv(1, 32'h0000_0300, 1, 32'h0000_4008, 1, 0); tick();
        drv(1, 32'h0000_0300, 1, 32'h0000_4008, 1, 1); tick();
        drv(1, 32'h0000_0300, 1, 32'h0000_4008, 1, 1); tick();
        drv(1, 32'h0000_0300, 0, 32'h0000_4008, 1, 0); tick();
        drv(0, 32'h0, 0, 32'h0, 0, 1); repeat (3) tick();

        // Continuous contention with a response every cycle.
        drv(1, 32'h0000_0500, 1, 32'h0000_5000, 1, 0); tick();
        drv(1, 32'h0000_0504, 1, 32'h0000_5004, 1, 1); repeat (6) tick();
        drv(0, 32'h0, 0, 32'h0, 0, 1); repeat (3) tick();

        // Spurious responses, and reset with transactions in flight.
        drv(0, 32'h0, 0, 32'h0, 0, 1); repeat (2) tick();
        drv(1, 32'h0000_0600, 1, 32'h0000_6000, 1, 0); repeat (2) tick();
        rst = 1'b1; drv(0, 32'h0, 0, 32'h0, 0, 0); tick();
        rst = 1'b0; drv(0, 32'h0, 0, 32'h0, 0, 1); repeat (2) tick();

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 300) == 0;
            for (int k = 0; k < 2; k++) rnd_next(k);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
